// File: rtl/riscv_rf_sched_pkg.sv
// ---------------------------------------------------------------------------
// riscv_rf_sched_pkg
// Shared types and constants for the register-file writeback scheduler.
//   ADDR_WIDTH_DEF / DATA_WIDTH_DEF : default register address / data widths
//   NUM_REGS                        : number of architectural registers
//   wb_src_e                        : which unit produced a registered write
//   wb_req_t                        : one registered write-port request
//   clears_busy()                   : true for sources that retire long ops
// ---------------------------------------------------------------------------
package riscv_rf_sched_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int NUM_REGS       = 2 ** ADDR_WIDTH_DEF;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_MUL,
        SRC_LSU
    } wb_src_e;

    // valid here already folds in the x0 filter: it is the register-file
    // write enable, not merely "a handshake happened".
    typedef struct packed {
        logic                      valid;
        logic [ADDR_WIDTH_DEF-1:0] rd;
        logic [DATA_WIDTH_DEF-1:0] wdata;
    } wb_req_t;

    // Only long-latency units own scoreboard entries; ALU results never
    // retire a busy bit.
    function automatic logic clears_busy(input wb_src_e src);
        return (src == SRC_MUL) || (src == SRC_LSU);
    endfunction

endpackage

// File: rtl/riscv_rf_wb_scheduler_if.sv
// ---------------------------------------------------------------------------
// riscv_rf_wb_scheduler_if
// Bundles the issue, writeback-handshake and register-file write signals of
// the writeback scheduler.
//   slave  : seen by the scheduler (issue/ALU/MUL/LSU in, ready + RF ports out)
//   master : seen by the ID/EX side driving the scheduler
// ---------------------------------------------------------------------------
interface riscv_rf_wb_scheduler_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    // issue / hazard
    logic                  issue_valid_i;
    logic                  issue_long_i;
    logic [ADDR_WIDTH-1:0] issue_rd_i;
    logic [ADDR_WIDTH-1:0] issue_rs_a_i;
    logic [ADDR_WIDTH-1:0] issue_rs_b_i;
    logic [ADDR_WIDTH-1:0] issue_rs_c_i;
    logic                  issue_rs_c_en_i;
    logic                  issue_ready_o;
    // ALU writeback
    logic                  alu_valid_i;
    logic                  alu_ready_o;
    logic [ADDR_WIDTH-1:0] alu_rd_i;
    logic [DATA_WIDTH-1:0] alu_wdata_i;
    // multiplier writeback
    logic                  mul_valid_i;
    logic                  mul_ready_o;
    logic [ADDR_WIDTH-1:0] mul_rd_i;
    logic [DATA_WIDTH-1:0] mul_wdata_i;
    // load writeback (no backpressure)
    logic                  lsu_valid_i;
    logic [ADDR_WIDTH-1:0] lsu_rd_i;
    logic [DATA_WIDTH-1:0] lsu_wdata_i;
    // register file write ports
    logic                  we_a_o;
    logic [ADDR_WIDTH-1:0] waddr_a_o;
    logic [DATA_WIDTH-1:0] wdata_a_o;
    logic                  we_b_o;
    logic [ADDR_WIDTH-1:0] waddr_b_o;
    logic [DATA_WIDTH-1:0] wdata_b_o;
    // scoreboard
    logic [NUM_REGS-1:0]   busy_o;

    modport slave (
        input  issue_valid_i, issue_long_i, issue_rd_i,
               issue_rs_a_i, issue_rs_b_i, issue_rs_c_i, issue_rs_c_en_i,
               alu_valid_i, alu_rd_i, alu_wdata_i,
               mul_valid_i, mul_rd_i, mul_wdata_i,
               lsu_valid_i, lsu_rd_i, lsu_wdata_i,
        output issue_ready_o, alu_ready_o, mul_ready_o,
               we_a_o, waddr_a_o, wdata_a_o,
               we_b_o, waddr_b_o, wdata_b_o,
               busy_o
    );

    modport master (
        output issue_valid_i, issue_long_i, issue_rd_i,
               issue_rs_a_i, issue_rs_b_i, issue_rs_c_i, issue_rs_c_en_i,
               alu_valid_i, alu_rd_i, alu_wdata_i,
               mul_valid_i, mul_rd_i, mul_wdata_i,
               lsu_valid_i, lsu_rd_i, lsu_wdata_i,
        input  issue_ready_o, alu_ready_o, mul_ready_o,
               we_a_o, waddr_a_o, wdata_a_o,
               we_b_o, waddr_b_o, wdata_b_o,
               busy_o
    );

endinterface

// File: rtl/riscv_rf_scoreboard.sv
// ---------------------------------------------------------------------------
// riscv_rf_scoreboard
// One busy bit per register for in-flight long-latency destinations.
//   clk, rst_n           : clock, asynchronous active-low reset
//   set_en_i / set_rd_i  : mark rd busy (long op issued)
//   clr_a_*, clr_b_*     : retire rd (long-op write visible on RF port A/B)
//   rs_a/b/c_i, rs_c_en_i, rd_i : operands of the instruction at issue
//   busy_o               : busy vector, bit 0 constant 0
//   hazard_o             : RAW on any used source or WAW on rd
// ---------------------------------------------------------------------------
module riscv_rf_scoreboard #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       set_en_i,
    input  logic [ADDR_WIDTH-1:0]      set_rd_i,
    input  logic                       clr_a_en_i,
    input  logic [ADDR_WIDTH-1:0]      clr_a_rd_i,
    input  logic                       clr_b_en_i,
    input  logic [ADDR_WIDTH-1:0]      clr_b_rd_i,
    input  logic [ADDR_WIDTH-1:0]      rs_a_i,
    input  logic [ADDR_WIDTH-1:0]      rs_b_i,
    input  logic [ADDR_WIDTH-1:0]      rs_c_i,
    input  logic                       rs_c_en_i,
    input  logic [ADDR_WIDTH-1:0]      rd_i,
    output logic [2**ADDR_WIDTH-1:0]   busy_o,
    output logic                       hazard_o
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // x0 is never tracked, so sources/rd equal to x0 can never stall.
    assign busy_d[0] = 1'b0;

    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
        localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(gi);
        logic set_hit;
        logic clr_hit;
        assign set_hit    = set_en_i && (set_rd_i == IDX);
        assign clr_hit    = (clr_a_en_i && (clr_a_rd_i == IDX)) ||
                            (clr_b_en_i && (clr_b_rd_i == IDX));
        // A new long op to the same rd outranks the retirement of the old one.
        assign busy_d[gi] = set_hit || (busy_q[gi] && !clr_hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o   = busy_q;
    assign hazard_o = busy_q[rs_a_i] || busy_q[rs_b_i] ||
                      (rs_c_en_i && busy_q[rs_c_i]) || busy_q[rd_i];

endmodule

// File: rtl/riscv_rf_wb_scheduler.sv
// ---------------------------------------------------------------------------
// riscv_rf_wb_scheduler
// Arbitrates ALU / MUL / LSU results onto the two register-file write ports
// and stalls issue on scoreboard hazards.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : riscv_rf_wb_scheduler_if.slave
//                issue_*   -> issue_ready_o (combinational hazard check)
//                alu_*     -> alu_ready_o  (may stall on port A contention)
//                mul_*     -> mul_ready_o  (always 1, owns port A)
//                lsu_*     (always accepted, owns port B)
//                we/waddr/wdata_{a,b}_o : registered RF write ports
//                busy_o    : scoreboard
// ---------------------------------------------------------------------------
module riscv_rf_wb_scheduler
    import riscv_rf_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    riscv_rf_wb_scheduler_if.slave  bus
);
    logic    alu_ready;
    logic    alu_accept;
    logic    hazard;
    logic    issue_set;
    logic    clr_a_en;
    logic    clr_b_en;
    logic [2**ADDR_WIDTH-1:0] busy;

    wb_req_t port_a_d, port_a_q;
    wb_req_t port_b_d, port_b_q;
    wb_src_e src_a_d, src_a_q;
    wb_src_e src_b_d, src_b_q;

    // ALU yields port A to the MUL. It can borrow port B only if the LSU is
    // idle, and never alongside a MUL write to the same rd so that the later
    // ALU value is the one left in the register file.
    assign alu_ready  = !bus.mul_valid_i ||
                        (!bus.lsu_valid_i && (bus.alu_rd_i != bus.mul_rd_i));
    assign alu_accept = bus.alu_valid_i && alu_ready;

    always_comb begin
        port_a_d = '0;
        port_b_d = '0;
        src_a_d  = SRC_NONE;
        src_b_d  = SRC_NONE;

        if (bus.mul_valid_i) begin
            port_a_d.valid = (bus.mul_rd_i != '0);
            port_a_d.rd    = bus.mul_rd_i;
            port_a_d.wdata = bus.mul_wdata_i;
            src_a_d        = SRC_MUL;
        end else if (alu_accept) begin
            port_a_d.valid = (bus.alu_rd_i != '0);
            port_a_d.rd    = bus.alu_rd_i;
            port_a_d.wdata = bus.alu_wdata_i;
            src_a_d        = SRC_ALU;
        end

        if (bus.lsu_valid_i) begin
            port_b_d.valid = (bus.lsu_rd_i != '0);
            port_b_d.rd    = bus.lsu_rd_i;
            port_b_d.wdata = bus.lsu_wdata_i;
            src_b_d        = SRC_LSU;
        end else if (bus.mul_valid_i && alu_accept) begin
            port_b_d.valid = (bus.alu_rd_i != '0);
            port_b_d.rd    = bus.alu_rd_i;
            port_b_d.wdata = bus.alu_wdata_i;
            src_b_d        = SRC_ALU;
        end
    end

    // Asynchronous reset drops any write already sitting in the port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_a_q <= '0;
            port_b_q <= '0;
            src_a_q  <= SRC_NONE;
            src_b_q  <= SRC_NONE;
        end else begin
            port_a_q <= port_a_d;
            port_b_q <= port_b_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
        end
    end

    // The busy bit drops one cycle after the write is on the port, i.e. once
    // the register file actually holds the value; no bypass path needed.
    assign clr_a_en  = port_a_q.valid && clears_busy(src_a_q);
    assign clr_b_en  = port_b_q.valid && clears_busy(src_b_q);
    assign issue_set = bus.issue_valid_i && !hazard && bus.issue_long_i &&
                       (bus.issue_rd_i != '0);

    riscv_rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en_i   (issue_set),
        .set_rd_i   (bus.issue_rd_i),
        .clr_a_en_i (clr_a_en),
        .clr_a_rd_i (ADDR_WIDTH'(port_a_q.rd)),
        .clr_b_en_i (clr_b_en),
        .clr_b_rd_i (ADDR_WIDTH'(port_b_q.rd)),
        .rs_a_i     (bus.issue_rs_a_i),
        .rs_b_i     (bus.issue_rs_b_i),
        .rs_c_i     (bus.issue_rs_c_i),
        .rs_c_en_i  (bus.issue_rs_c_en_i),
        .rd_i       (bus.issue_rd_i),
        .busy_o     (busy),
        .hazard_o   (hazard)
    );

    assign bus.busy_o        = busy;
    assign bus.issue_ready_o = !hazard;
    assign bus.alu_ready_o   = alu_ready;
    assign bus.mul_ready_o   = 1'b1;

    assign bus.we_a_o    = port_a_q.valid;
    assign bus.waddr_a_o = ADDR_WIDTH'(port_a_q.rd);
    assign bus.wdata_a_o = DATA_WIDTH'(port_a_q.wdata);
    assign bus.we_b_o    = port_b_q.valid;
    assign bus.waddr_b_o = ADDR_WIDTH'(port_b_q.rd);
    assign bus.wdata_b_o = DATA_WIDTH'(port_b_q.wdata);

endmodule

// File: tb/tb_riscv_rf_wb_scheduler.sv
`timescale 1ns/1ps
module tb_riscv_rf_wb_scheduler;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    riscv_rf_wb_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    riscv_rf_wb_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Register file as seen through the write ports.
    logic [DW-1:0] rf_obs [NR];
    initial for (int i = 0; i < NR; i++) rf_obs[i] = '0;
    always @(posedge clk) begin
        if (bus.we_a_o) rf_obs[bus.waddr_a_o] <= bus.wdata_a_o;
        if (bus.we_b_o) rf_obs[bus.waddr_b_o] <= bus.wdata_b_o;
    end

    task automatic drive_idle();
        bus.issue_valid_i = 0; bus.issue_long_i = 0; bus.issue_rd_i = '0;
        bus.issue_rs_a_i = '0; bus.issue_rs_b_i = '0; bus.issue_rs_c_i = '0;
        bus.issue_rs_c_en_i = 0;
        bus.alu_valid_i = 0; bus.alu_rd_i = '0; bus.alu_wdata_i = '0;
        bus.mul_valid_i = 0; bus.mul_rd_i = '0; bus.mul_wdata_i = '0;
        bus.lsu_valid_i = 0; bus.lsu_rd_i = '0; bus.lsu_wdata_i = '0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 0;
        repeat (2) @(negedge clk);
        tests_run++; if ({bus.we_a_o, bus.we_b_o} !== 2'b00) begin tests_failed++; $display("FAIL reset_we: got %b expected 00", {bus.we_a_o, bus.we_b_o}); end
        tests_run++; if (bus.busy_o !== '0) begin tests_failed++; $display("FAIL reset_busy: got %h expected 0", bus.busy_o); end
        tests_run++; if (bus.issue_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_issue_ready: got %b expected 1", bus.issue_ready_o); end
        rst_n = 1;
        @(negedge clk);
        bus.alu_valid_i = 1; bus.alu_rd_i = 5'd1; bus.alu_wdata_i = 32'h1234_5678;
        bus.issue_valid_i = 1; bus.issue_long_i = 1; bus.issue_rd_i = 5'd2;
        @(posedge clk); #2;
        drive_idle();
        tests_run++; if (bus.we_a_o !== 1'b1) begin tests_failed++; $display("FAIL reset_pending_we_a: got %b expected 1", bus.we_a_o); end
        tests_run++; if (bus.busy_o[2] !== 1'b1) begin tests_failed++; $display("FAIL reset_pending_busy2: got %b expected 1", bus.busy_o[2]); end
        rst_n = 0;
        #1;
        tests_run++; if ({bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o} !== '0) begin tests_failed++; $display("FAIL reset_async_port_a: got we=%b addr=%0d data=%h expected all 0", bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o); end
        tests_run++; if ({bus.we_b_o, bus.waddr_b_o, bus.wdata_b_o} !== '0) begin tests_failed++; $display("FAIL reset_async_port_b: got we=%b addr=%0d data=%h expected all 0", bus.we_b_o, bus.waddr_b_o, bus.wdata_b_o); end
        tests_run++; if (bus.busy_o !== '0) begin tests_failed++; $display("FAIL reset_async_busy: got %h expected 0", bus.busy_o); end
        @(negedge clk);
        rst_n = 1;
        $display("[TB] test_reset done");
    endtask

    task automatic test_long_hazard();
        @(negedge clk);
        bus.issue_valid_i = 1; bus.issue_long_i = 1; bus.issue_rd_i = 5'd5;
        #1;
        tests_run++; if (bus.issue_ready_o !== 1'b1) begin tests_failed++; $display("FAIL hz_first_issue: got %b expected 1", bus.issue_ready_o); end
        @(negedge clk);
        bus.issue_long_i = 0; bus.issue_rd_i = 5'd10; bus.issue_rs_a_i = 5'd5;
        bus.lsu_valid_i = 1; bus.lsu_rd_i = 5'd5; bus.lsu_wdata_i = 32'hDEAD_BEEF;
        #1;
        tests_run++; if (bus.issue_ready_o !== 1'b0) begin tests_failed++; $display("FAIL hz_stall_t0: got %b expected 0", bus.issue_ready_o); end
        tests_run++; if (bus.busy_o[5] !== 1'b1) begin tests_failed++; $display("FAIL hz_busy5_set: got %b expected 1", bus.busy_o[5]); end
        @(negedge clk);
        bus.lsu_valid_i = 0;
        tests_run++; if ({bus.we_b_o, bus.waddr_b_o, bus.wdata_b_o} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin tests_failed++; $display("FAIL hz_port_b: got we=%b addr=%0d data=%h expected 1/5/deadbeef", bus.we_b_o, bus.waddr_b_o, bus.wdata_b_o); end
        #1;
        tests_run++; if (bus.issue_ready_o !== 1'b0) begin tests_failed++; $display("FAIL hz_stall_t1: got %b expected 0", bus.issue_ready_o); end
        @(negedge clk);
        #1;
        tests_run++; if (bus.issue_ready_o !== 1'b1) begin tests_failed++; $display("FAIL hz_release: got %b expected 1", bus.issue_ready_o); end
        tests_run++; if (bus.busy_o[5] !== 1'b0) begin tests_failed++; $display("FAIL hz_busy5_clear: got %b expected 0", bus.busy_o[5]); end
        tests_run++; if (rf_obs[5] !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL hz_rf5: got %h expected deadbeef", rf_obs[5]); end
        @(negedge clk);
        drive_idle();
        $display("[TB] test_long_hazard done");
    endtask

    task automatic test_three_way();
        @(negedge clk);
        bus.mul_valid_i = 1; bus.mul_rd_i = 5'd3; bus.mul_wdata_i = 32'h33;
        bus.alu_valid_i = 1; bus.alu_rd_i = 5'd4; bus.alu_wdata_i = 32'h44;
        bus.lsu_valid_i = 1; bus.lsu_rd_i = 5'd7; bus.lsu_wdata_i = 32'h77;
        #1;
        tests_run++; if (bus.alu_ready_o !== 1'b0) begin tests_failed++; $display("FAIL three_alu_ready: got %b expected 0", bus.alu_ready_o); end
        tests_run++; if (bus.mul_ready_o !== 1'b1) begin tests_failed++; $display("FAIL three_mul_ready: got %b expected 1", bus.mul_ready_o); end
        @(negedge clk);
        bus.mul_valid_i = 0; bus.lsu_valid_i = 0;
        tests_run++; if ({bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o} !== {1'b1, 5'd3, 32'h33}) begin tests_failed++; $display("FAIL three_port_a: got we=%b addr=%0d data=%h expected 1/3/33", bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o); end
        tests_run++; if ({bus.we_b_o, bus.waddr_b_o, bus.wdata_b_o} !== {1'b1, 5'd7, 32'h77}) begin tests_failed++; $display("FAIL three_port_b: got we=%b addr=%0d data=%h expected 1/7/77", bus.we_b_o, bus.waddr_b_o, bus.wdata_b_o); end
        #1;
        tests_run++; if (bus.alu_ready_o !== 1'b1) begin tests_failed++; $display("FAIL three_alu_ready_retry: got %b expected 1", bus.alu_ready_o); end
        @(negedge clk);
        bus.alu_valid_i = 0;
        tests_run++; if ({bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o} !== {1'b1, 5'd4, 32'h44}) begin tests_failed++; $display("FAIL three_alu_late: got we=%b addr=%0d data=%h expected 1/4/44", bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o); end
        tests_run++; if (bus.we_b_o !== 1'b0) begin tests_failed++; $display("FAIL three_port_b_idle: got %b expected 0", bus.we_b_o); end
        $display("[TB] test_three_way done");
    endtask

    task automatic test_alu_fallback();
        @(negedge clk);
        bus.mul_valid_i = 1; bus.mul_rd_i = 5'd3; bus.mul_wdata_i = 32'h3A;
        bus.alu_valid_i = 1; bus.alu_rd_i = 5'd4; bus.alu_wdata_i = 32'h4B;
        #1;
        tests_run++; if (bus.alu_ready_o !== 1'b1) begin tests_failed++; $display("FAIL fb_alu_ready: got %b expected 1", bus.alu_ready_o); end
        @(negedge clk);
        drive_idle();
        tests_run++; if ({bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o} !== {1'b1, 5'd3, 32'h3A}) begin tests_failed++; $display("FAIL fb_port_a: got we=%b addr=%0d data=%h expected 1/3/3a", bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o); end
        tests_run++; if ({bus.we_b_o, bus.waddr_b_o, bus.wdata_b_o} !== {1'b1, 5'd4, 32'h4B}) begin tests_failed++; $display("FAIL fb_port_b: got we=%b addr=%0d data=%h expected 1/4/4b", bus.we_b_o, bus.waddr_b_o, bus.wdata_b_o); end
        $display("[TB] test_alu_fallback done");
    endtask

    task automatic test_same_rd();
        @(negedge clk);
        bus.mul_valid_i = 1; bus.mul_rd_i = 5'd9; bus.mul_wdata_i = 32'h1;
        bus.alu_valid_i = 1; bus.alu_rd_i = 5'd9; bus.alu_wdata_i = 32'h2;
        #1;
        tests_run++; if (bus.alu_ready_o !== 1'b0) begin tests_failed++; $display("FAIL same_alu_ready: got %b expected 0", bus.alu_ready_o); end
        @(negedge clk);
        bus.mul_valid_i = 0;
        tests_run++; if ({bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o} !== {1'b1, 5'd9, 32'h1}) begin tests_failed++; $display("FAIL same_mul_write: got we=%b addr=%0d data=%h expected 1/9/1", bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o); end
        tests_run++; if (bus.we_b_o !== 1'b0) begin tests_failed++; $display("FAIL same_port_b_idle: got %b expected 0", bus.we_b_o); end
        @(negedge clk);
        bus.alu_valid_i = 0;
        tests_run++; if ({bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o} !== {1'b1, 5'd9, 32'h2}) begin tests_failed++; $display("FAIL same_alu_write: got we=%b addr=%0d data=%h expected 1/9/2", bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o); end
        @(negedge clk);
        tests_run++; if (rf_obs[9] !== 32'h2) begin tests_failed++; $display("FAIL same_rf9: got %h expected 2", rf_obs[9]); end
        $display("[TB] test_same_rd done");
    endtask

    task automatic test_x0_set_wins();
        @(negedge clk);
        bus.alu_valid_i = 1; bus.alu_rd_i = 5'd0; bus.alu_wdata_i = 32'hFF;
        #1;
        tests_run++; if (bus.alu_ready_o !== 1'b1) begin tests_failed++; $display("FAIL x0_alu_ready: got %b expected 1", bus.alu_ready_o); end
        @(negedge clk);
        bus.alu_valid_i = 0;
        tests_run++; if ({bus.we_a_o, bus.we_b_o} !== 2'b00) begin tests_failed++; $display("FAIL x0_no_we: got %b expected 00", {bus.we_a_o, bus.we_b_o}); end
        bus.mul_valid_i = 1; bus.mul_rd_i = 5'd6; bus.mul_wdata_i = 32'h66;
        @(negedge clk);
        bus.mul_valid_i = 0;
        bus.issue_valid_i = 1; bus.issue_long_i = 1; bus.issue_rd_i = 5'd6;
        tests_run++; if ({bus.we_a_o, bus.waddr_a_o} !== {1'b1, 5'd6}) begin tests_failed++; $display("FAIL sw_mul_write: got we=%b addr=%0d expected 1/6", bus.we_a_o, bus.waddr_a_o); end
        #1;
        tests_run++; if (bus.issue_ready_o !== 1'b1) begin tests_failed++; $display("FAIL sw_issue_ready: got %b expected 1", bus.issue_ready_o); end
        @(negedge clk);
        drive_idle();
        #1;
        tests_run++; if (bus.busy_o[6] !== 1'b1) begin tests_failed++; $display("FAIL sw_busy6_set_wins: got %b expected 1", bus.busy_o[6]); end
        bus.lsu_valid_i = 1; bus.lsu_rd_i = 5'd6; bus.lsu_wdata_i = 32'h606;
        @(negedge clk);
        bus.lsu_valid_i = 0;
        @(negedge clk);
        #1;
        tests_run++; if (bus.busy_o[6] !== 1'b0) begin tests_failed++; $display("FAIL sw_busy6_cleared: got %b expected 0", bus.busy_o[6]); end
        $display("[TB] test_x0_set_wins done");
    endtask

    // Randomised traffic against a cycle-level model of the scheduling rules.
    task automatic test_random();
        bit            m_busy [NR];
        bit            m_written [NR];
        logic [DW-1:0] m_rf [NR];
        logic [NR-1:0] exp_busy;
        bit            pa_we, pb_we, na_we, nb_we;
        bit            pa_clr, pb_clr, na_clr, nb_clr;
        logic [AW-1:0] pa_rd, pb_rd, na_rd, nb_rd;
        logic [DW-1:0] pa_d, pb_d, na_d, nb_d;
        bit            alu_hold, e_alu_rdy, e_iss_rdy;
        int            rand_fail_start;

        for (int i = 0; i < NR; i++) begin m_busy[i] = 0; m_written[i] = 0; m_rf[i] = '0; end
        pa_we = 0; pb_we = 0; pa_clr = 0; pb_clr = 0;
        pa_rd = '0; pb_rd = '0; pa_d = '0; pb_d = '0;
        alu_hold = 0;
        rand_fail_start = tests_failed;

        drive_idle();
        @(negedge clk);
        rst_n = 0;
        #1;
        rst_n = 1;

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            tests_run++; if (bus.we_a_o !== pa_we) begin tests_failed++; $display("FAIL rnd_we_a cyc=%0d: got %b expected %b", cyc, bus.we_a_o, pa_we); end
            if (pa_we) begin
                tests_run++; if ({bus.waddr_a_o, bus.wdata_a_o} !== {pa_rd, pa_d}) begin tests_failed++; $display("FAIL rnd_port_a cyc=%0d: got %0d/%h expected %0d/%h", cyc, bus.waddr_a_o, bus.wdata_a_o, pa_rd, pa_d); end
            end
            tests_run++; if (bus.we_b_o !== pb_we) begin tests_failed++; $display("FAIL rnd_we_b cyc=%0d: got %b expected %b", cyc, bus.we_b_o, pb_we); end
            if (pb_we) begin
                tests_run++; if ({bus.waddr_b_o, bus.wdata_b_o} !== {pb_rd, pb_d}) begin tests_failed++; $display("FAIL rnd_port_b cyc=%0d: got %0d/%h expected %0d/%h", cyc, bus.waddr_b_o, bus.wdata_b_o, pb_rd, pb_d); end
            end

            if (!alu_hold) begin
                bus.alu_valid_i = ($urandom_range(0, 99) < 60);
                bus.alu_rd_i    = AW'($urandom_range(0, 7));
                bus.alu_wdata_i = $urandom;
            end
            bus.mul_valid_i     = ($urandom_range(0, 99) < 35);
            bus.mul_rd_i        = AW'($urandom_range(0, 7));
            bus.mul_wdata_i     = $urandom;
            bus.lsu_valid_i     = ($urandom_range(0, 99) < 30);
            bus.lsu_rd_i        = AW'($urandom_range(0, 7));
            bus.lsu_wdata_i     = $urandom;
            bus.issue_valid_i   = ($urandom_range(0, 99) < 70);
            bus.issue_long_i    = ($urandom_range(0, 99) < 50);
            bus.issue_rd_i      = AW'($urandom_range(0, 7));
            bus.issue_rs_a_i    = AW'($urandom_range(0, 7));
            bus.issue_rs_b_i    = AW'($urandom_range(0, 7));
            bus.issue_rs_c_i    = AW'($urandom_range(0, 7));
            bus.issue_rs_c_en_i = ($urandom_range(0, 1) == 1);
            #1;

            e_alu_rdy = !bus.mul_valid_i || (!bus.lsu_valid_i && (bus.alu_rd_i != bus.mul_rd_i));
            e_iss_rdy = !(m_busy[bus.issue_rs_a_i] || m_busy[bus.issue_rs_b_i] ||
                          (bus.issue_rs_c_en_i && m_busy[bus.issue_rs_c_i]) || m_busy[bus.issue_rd_i]);
            for (int r = 0; r < NR; r++) exp_busy[r] = m_busy[r];

            tests_run++; if (bus.busy_o !== exp_busy) begin tests_failed++; $display("FAIL rnd_busy cyc=%0d: got %h expected %h", cyc, bus.busy_o, exp_busy); end
            tests_run++; if (bus.alu_ready_o !== e_alu_rdy) begin tests_failed++; $display("FAIL rnd_alu_ready cyc=%0d: got %b expected %b", cyc, bus.alu_ready_o, e_alu_rdy); end
            tests_run++; if (bus.mul_ready_o !== 1'b1) begin tests_failed++; $display("FAIL rnd_mul_ready cyc=%0d: got %b expected 1", cyc, bus.mul_ready_o); end
            tests_run++; if (bus.issue_ready_o !== e_iss_rdy) begin tests_failed++; $display("FAIL rnd_issue_ready cyc=%0d: got %b expected %b", cyc, bus.issue_ready_o, e_iss_rdy); end

            // Writes on the ports now land in the RF at this edge and retire
            // long ops; a same-cycle long issue to that rd re-marks it busy.
            if (pa_we) begin m_rf[pa_rd] = pa_d; m_written[pa_rd] = 1; if (pa_clr) m_busy[pa_rd] = 0; end
            if (pb_we) begin m_rf[pb_rd] = pb_d; m_written[pb_rd] = 1; if (pb_clr) m_busy[pb_rd] = 0; end
            if (bus.issue_valid_i && e_iss_rdy && bus.issue_long_i && bus.issue_rd_i != 0) m_busy[bus.issue_rd_i] = 1;

            na_we = 0; na_clr = 0; na_rd = '0; na_d = '0;
            nb_we = 0; nb_clr = 0; nb_rd = '0; nb_d = '0;
            if (bus.mul_valid_i) begin
                na_we = (bus.mul_rd_i != 0); na_clr = 1; na_rd = bus.mul_rd_i; na_d = bus.mul_wdata_i;
            end else if (bus.alu_valid_i && e_alu_rdy) begin
                na_we = (bus.alu_rd_i != 0); na_clr = 0; na_rd = bus.alu_rd_i; na_d = bus.alu_wdata_i;
            end
            if (bus.lsu_valid_i) begin
                nb_we = (bus.lsu_rd_i != 0); nb_clr = 1; nb_rd = bus.lsu_rd_i; nb_d = bus.lsu_wdata_i;
            end else if (bus.mul_valid_i && bus.alu_valid_i && e_alu_rdy) begin
                nb_we = (bus.alu_rd_i != 0); nb_clr = 0; nb_rd = bus.alu_rd_i; nb_d = bus.alu_wdata_i;
            end
            alu_hold = bus.alu_valid_i && !e_alu_rdy;
            pa_we = na_we; pa_clr = na_clr; pa_rd = na_rd; pa_d = na_d;
            pb_we = nb_we; pb_clr = nb_clr; pb_rd = nb_rd; pb_d = nb_d;
        end

        @(negedge clk);
        drive_idle();
        if (pa_we) begin m_rf[pa_rd] = pa_d; m_written[pa_rd] = 1; end
        if (pb_we) begin m_rf[pb_rd] = pb_d; m_written[pb_rd] = 1; end
        repeat (2) @(negedge clk);
        for (int r = 1; r < 8; r++) begin
            if (m_written[r]) begin
                tests_run++; if (rf_obs[r] !== m_rf[r]) begin tests_failed++; $display("FAIL rnd_rf x%0d: got %h expected %h", r, rf_obs[r], m_rf[r]); end
            end
        end
        $display("[TB] test_random done, %0d new failures", tests_failed - rand_fail_start);
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_long_hazard();
        test_three_way();
        test_alu_fallback();
        test_same_rd();
        test_x0_set_wins();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/riscv_rf_wb_scheduler.md
# riscv_rf_wb_scheduler

Writeback scheduler and scoreboard for the two-write-port, three-read-port flip-flop register file (31 × 32-bit, x0 hard-wired to zero). It arbitrates results from the ALU, multiplier and LSU onto write ports A and B. It tracks destination registers of in-flight long-latency operations and stalls issue on RAW/WAW hazards. Sits between the ID/EX stages and the register file.

## Interface
- ADDR_WIDTH, 5, register address width (NUM_REGS = 2**ADDR_WIDTH)
- DATA_WIDTH, 32, write data width

- clk  in  1  clock
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock clk
- issue_valid_i  in  1  decoder presents an instruction
- issue_long_i  in  1  instruction writes back via MUL or LSU
- issue_rd_i  in  ADDR_WIDTH  destination register
- issue_rs_a_i, issue_rs_b_i, issue_rs_c_i  in  ADDR_WIDTH each  source registers
- issue_rs_c_en_i  in  1  rs_c is used
- issue_ready_o  out  1  no hazard; the instruction issues when valid && ready
- alu_valid_i, alu_ready_o  in/out  1  ALU writeback handshake
- alu_rd_i, alu_wdata_i  in  ADDR_WIDTH / DATA_WIDTH  ALU result
- mul_valid_i, mul_ready_o  in/out  1  multiplier writeback handshake
- mul_rd_i, mul_wdata_i  in  ADDR_WIDTH / DATA_WIDTH  multiplier result
- lsu_valid_i  in  1  load result; always accepted, no ready
- lsu_rd_i, lsu_wdata_i  in  ADDR_WIDTH / DATA_WIDTH  load result
- we_a_o, waddr_a_o, wdata_a_o  out  1 / ADDR_WIDTH / DATA_WIDTH  register file write port A
- we_b_o, waddr_b_o, wdata_b_o  out  1 / ADDR_WIDTH / DATA_WIDTH  register file write port B
- busy_o  out  NUM_REGS  scoreboard; bit 0 is always 0

## Operation
- **Port B owner:** LSU. A load in cycle T is written on port B in T+1.
- **Port A arbitration:** MUL has priority over ALU.
  - mul_ready_o = 1 always.
  - alu_ready_o = !mul_valid_i || (!lsu_valid_i && alu_rd_i != mul_rd_i).
- **ALU fallback:** when MUL and ALU are both accepted in the same cycle, the ALU result goes to port B. This is possible only when the LSU is idle.
- **Same-rd conflict:** if the ALU and MUL target the same nonzero rd, the ALU stalls one cycle, so the ALU value lands last.
- **Writes to x0:** accepted, but the corresponding we_*_o stays 0.
- **Scoreboard set:** busy[rd] is set on issue_valid_i && issue_ready_o && issue_long_i && rd != 0.
- **Scoreboard clear:** busy[rd] is cleared when the write to rd has completed in the register file. A MUL or LSU write output with we=1 in cycle T+1 clears the bit from T+2.
  - ALU writes never clear busy bits.
- **Simultaneous set and clear of the same rd:** set wins.
- **Hazard stall:** issue_ready_o = 0 when any of the following is busy: busy[rs_a], busy[rs_b], busy[rs_c] (only when issue_rs_c_en_i), or busy[rd] (WAW).
  - issue_ready_o is combinational.
  - Sources equal to x0 never stall.
- **Spurious write:** an LSU or MUL write to an rd whose busy bit is clear is legal and is written normally.

## Timing
- Write outputs are registered: 1-cycle latency from accepted handshake to we_*_o.
- Reset values: every output is 0; the busy vector is 0; issue_ready_o = 1 once no hazard exists.
- **Reset mid-operation:**
  - pending registered writes are dropped (we_*_o = 0 immediately, asynchronously);
  - the scoreboard is cleared.
- **Back-to-back:** the ALU may write every cycle. MUL and ALU writes in the same cycle both retire when the LSU is idle.
- **Port A collision:** an ALU stalled on port A holds alu_valid_i and its data stable until ready. The block never drops an ALU result.
- **Read-after-write:** an instruction stalled on busy[r] issues in the cycle the bit drops. In that cycle the register file already holds the new value, so no bypass is needed.

## Structure
- Package riscv_rf_sched_pkg holds:
  - NUM_REGS;
  - the write-source enum wb_src_e {SRC_NONE, SRC_ALU, SRC_MUL, SRC_LSU};
  - the packed wb_req_t {valid, rd, wdata}.
- Sub-module riscv_rf_scoreboard: busy vector, set/clear logic with set priority, and hazard compare for three sources plus rd.
- The top level holds the port arbitration and the output registers.

## Test plan
- **Reset:** assert rst_n=0 mid-stream with we_a_o=1 pending → all outputs 0 asynchronously; busy_o = 0.
- **Long-op hazard:** issue long op rd=5, then issue rs_a=5 → issue_ready_o = 0 until the cycle after the LSU write to x5 (wdata 0xDEADBEEF) appears on port B; the RF then reads 0xDEADBEEF.
- **Three-way contention:** MUL rd=3, ALU rd=4 and LSU rd=7 all valid in one cycle → port A = x3, port B = x7, alu_ready_o = 0; the ALU writes x4 on port A the next cycle.
- **ALU fallback:** MUL rd=3 and ALU rd=4 valid with LSU idle → both accepted; port A = x3, port B = x4.
- **Same-rd conflict:** MUL rd=9 = 0x1 and ALU rd=9 = 0x2 → x9 ends at 0x2, with the ALU write one cycle later.
- **x0 writes and set-wins:** ALU writes x0 → no we; then issue long rd=6 in the same cycle as a MUL write to x6 clears it → busy[6] remains 1.
